// File: rtl/rgb2ycbcr_pipe_pkg.sv
// Shared types and constants for the RGB -> YCbCr colour converter.
//   rgb_t / ycbcr_t : packed pixels at the default 8-bit channel width
//                     (the pipeline itself uses flat CHANNEL_WIDTH vectors).
//   csc_mode_e      : per-pixel conversion mode.
//   COEF_BT601/709  : Q10 coefficient rows {Y, Cb, Cr}, columns {R, G, B}.
//   coef_q()        : coefficient lookup rescaled to an arbitrary fraction width.
package rgb2ycbcr_package;

  localparam int CHANNEL_WIDTH_DEF = 8;
  localparam int COEF_FRAC_REF     = 10;

  typedef struct packed {
    logic [CHANNEL_WIDTH_DEF-1:0] r;
    logic [CHANNEL_WIDTH_DEF-1:0] g;
    logic [CHANNEL_WIDTH_DEF-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic [CHANNEL_WIDTH_DEF-1:0] y;
    logic [CHANNEL_WIDTH_DEF-1:0] cb;
    logic [CHANNEL_WIDTH_DEF-1:0] cr;
  } ycbcr_t;

  typedef enum logic [1:0] {
    CSC_BT601  = 2'd0,
    CSC_BT709  = 2'd1,
    CSC_BYPASS = 2'd2,
    CSC_RSVD   = 2'd3   // treated as bypass
  } csc_mode_e;

  localparam int COEF_BT601 [3][3] = '{'{ 306,  601,  117},
                                       '{-173, -339,  512},
                                       '{ 512, -429,  -83}};
  localparam int COEF_BT709 [3][3] = '{'{ 218,  732,   74},
                                       '{-117, -395,  512},
                                       '{ 512, -465,  -47}};

  // Bypass modes never reach the dot product result, so anything that is not
  // BT709 may safely read the BT601 table.
  function automatic int coef_q(input logic [1:0] mode, input int row, input int col,
                                input int frac);
    int c;
    c = (mode == CSC_BT709) ? COEF_BT709[row][col] : COEF_BT601[row][col];
    if (frac >= COEF_FRAC_REF) return c <<< (frac - COEF_FRAC_REF);
    else                       return c >>> (COEF_FRAC_REF - frac);
  endfunction

endpackage

// File: rtl/rgb2ycbcr_pipe_csc_dot3.sv
// One output channel of the colour converter: signed 3-term dot product with
// rounding (S2), then arithmetic shift, chroma offset and clamp (S3).
//   clk_i, rst_i   : clock, async active-high reset
//   s2_en_i        : load S2 (products + sum) from the S1 pixel
//   s3_en_i        : load S3 (output register) from S2
//   mode_i         : csc mode of the pixel held in S1
//   r_i, g_i, b_i  : S1 pixel channels (unsigned)
//   res_o          : registered channel result (S3)
module csc_dot3 import rgb2ycbcr_package::*; #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int COEFF_FRAC    = 10,
  parameter int ROW           = 0    // 0 = Y, 1 = Cb, 2 = Cr
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s2_en_i,
  input  logic                     s3_en_i,
  input  logic [1:0]               mode_i,
  input  logic [CHANNEL_WIDTH-1:0] r_i,
  input  logic [CHANNEL_WIDTH-1:0] g_i,
  input  logic [CHANNEL_WIDTH-1:0] b_i,
  output logic [CHANNEL_WIDTH-1:0] res_o
);
  localparam int CW    = CHANNEL_WIDTH;
  // Worst-case |sum| stays below 2^(CW+COEFF_FRAC+1); two guard bits on top.
  localparam int ACC_W = CW + COEFF_FRAC + 3;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (COEFF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] OFS  = (ROW == 0) ? '0 : ACC_W'(1 << (CW - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << CW) - 1);

  logic signed [ACC_W-1:0] k0, k1, k2, r_s, g_s, b_s, acc_d, acc_q, val;
  logic [CW-1:0]           pass_d, pass_q, res_d;
  logic                    byp_q;

  assign k0  = ACC_W'(coef_q(mode_i, ROW, 0, COEFF_FRAC));
  assign k1  = ACC_W'(coef_q(mode_i, ROW, 1, COEFF_FRAC));
  assign k2  = ACC_W'(coef_q(mode_i, ROW, 2, COEFF_FRAC));
  assign r_s = $signed(ACC_W'(r_i));
  assign g_s = $signed(ACC_W'(g_i));
  assign b_s = $signed(ACC_W'(b_i));

  assign acc_d  = k0 * r_s + k1 * g_s + k2 * b_s + RND;
  // Bypass maps r->y, g->cb, b->cr.
  assign pass_d = (ROW == 0) ? r_i : (ROW == 1) ? g_i : b_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      byp_q  <= 1'b0;
      pass_q <= '0;
    end else if (s2_en_i) begin
      acc_q  <= acc_d;
      byp_q  <= mode_i[1];          // modes 2 and 3 both bypass
      pass_q <= pass_d;
    end
  end

  always_comb begin
    val   = (acc_q >>> COEFF_FRAC) + OFS;
    res_d = val[CW-1:0];
    if (byp_q)              res_d = pass_q;
    else if (val[ACC_W-1])  res_d = '0;
    else if (val > MAXV)    res_d = MAXV[CW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        res_o <= '0;
    else if (s3_en_i) res_o <= res_d;
  end

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// Stall-capable 3-stage RGB -> YCbCr converter (BT601 / BT709 / bypass per pixel).
//   clk_i, rst_i            : clock, async active-high reset
//   clear_i                 : synchronous flush of pipeline and pixel counter
//   in_valid_i/in_ready_o   : input handshake; in_pixel_i = {r,g,b}
//   in_mode_i, in_last_i    : per-pixel mode and end-of-frame, travel with pixel
//   out_valid_o/out_ready_i : output handshake; out_pixel_o = {y,cb,cr}
//   out_last_o              : end-of-frame aligned with out_pixel_o
//   pix_cnt_o               : output handshakes since reset/clear (wrapping)
module rgb2ycbcr_pipe import rgb2ycbcr_package::*; #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int COEFF_FRAC    = 10,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [3*CHANNEL_WIDTH-1:0] in_pixel_i,
  input  logic [1:0]                 in_mode_i,
  input  logic                       in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [3*CHANNEL_WIDTH-1:0] out_pixel_o,
  output logic                       out_last_o,
  output logic [CNT_WIDTH-1:0]       pix_cnt_o
);
  localparam int CW = CHANNEL_WIDTH;

  logic              v1, v2, v3, ld1, ld2, ld3, in_hs;
  logic [3*CW-1:0]   pix1;
  logic [1:0]        mode1;
  logic              last1, last2, last3;

  // Load chain: a stage advances when empty or when its successor advances.
  assign ld3        = !v3 || out_ready_i;
  assign ld2        = !v2 || ld3;
  assign ld1        = !v1 || ld2;
  assign in_ready_o = ld1 && !clear_i;
  assign in_hs      = in_valid_i && in_ready_o;

  assign out_valid_o = v3;
  assign out_last_o  = last3;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
    end else if (clear_i) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_hs;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix1  <= '0;
      mode1 <= CSC_BT601;
      last1 <= 1'b0;
      last2 <= 1'b0;
      last3 <= 1'b0;
    end else begin
      if (in_hs) begin
        pix1  <= in_pixel_i;
        mode1 <= in_mode_i;
        last1 <= in_last_i;
      end
      if (ld2 && v1) last2 <= last1;
      if (ld3 && v2) last3 <= last2;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           pix_cnt_o <= '0;
    else if (clear_i)                    pix_cnt_o <= '0;
    else if (out_valid_o && out_ready_i) pix_cnt_o <= pix_cnt_o + 1'b1;
  end

  for (genvar g_row = 0; g_row < 3; g_row++) begin : g_ch
    csc_dot3 #(
      .CHANNEL_WIDTH (CW),
      .COEFF_FRAC    (COEFF_FRAC),
      .ROW           (g_row)
    ) u_dot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .s2_en_i (ld2 && v1),
      .s3_en_i (ld3 && v2),
      .mode_i  (mode1),
      .r_i     (pix1[3*CW-1 -: CW]),
      .g_i     (pix1[2*CW-1 -: CW]),
      .b_i     (pix1[CW-1:0]),
      .res_o   (out_pixel_o[(2-g_row)*CW +: CW])
    );
  end

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
module tb_rgb2ycbcr_pipe;
  logic        clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [23:0] in_pixel = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid, out_ready = 1'b0, out_last;
  logic [23:0] out_pixel;
  logic [31:0] pix_cnt;

  rgb2ycbcr_pipe #(.CHANNEL_WIDTH(8), .COEFF_FRAC(10), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pixel_i(in_pixel),
    .in_mode_i(in_mode), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pixel_o(out_pixel),
    .out_last_o(out_last), .pix_cnt_o(pix_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int K601 [3][3] = '{'{306, 601, 117}, '{-173, -339, 512}, '{512, -429, -83}};
  int K709 [3][3] = '{'{218, 732, 74},  '{-117, -395, 512}, '{512, -465, -47}};

  logic [24:0] q[$];            // expected {last, ycbcr} in order
  logic [24:0] prev_out;
  bit          stall_prev = 0, accepted;
  int          n_out, cyc_n = 0, first_cyc, last_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the conversion rules evaluated with plain integer arithmetic.
  function automatic logic [23:0] model(input logic [1:0] m, input logic [23:0] p);
    int c[3];
    int acc, v;
    logic [23:0] res;
    c[0] = p[23:16]; c[1] = p[15:8]; c[2] = p[7:0];
    if (m[1]) return p;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      acc = 512;
      for (int j = 0; j < 3; j++)
        acc += ((m == 2'd0) ? K601[i][j] : K709[i][j]) * c[j];
      v = acc >>> 10;
      if (i > 0) v += 128;
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
      res[(2-i)*8 +: 8] = v[7:0];
    end
    return res;
  endfunction

  // One clock cycle; inputs already driven at the negedge by the caller.
  task automatic cyc();
    logic [24:0] e;
    #1;
    if (stall_prev)
      chk("stall_hold", {out_valid, out_last, out_pixel}, {1'b1, prev_out});
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("out_unexpected", out_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk($sformatf("out_px%0d", n_out), {out_last, out_pixel}, e);
      end
      if (n_out == 0) first_cyc = cyc_n;
      last_cyc = cyc_n;
      n_out++;
    end
    accepted = in_valid && in_ready;
    if (accepted) q.push_back({in_last, model(in_mode, in_pixel)});
    stall_prev = out_valid && !out_ready;
    prev_out   = {out_last, out_pixel};
    @(posedge clk); @(negedge clk);
    cyc_n++;
  endtask

  task automatic stream(input int n, input int p_valid, input int p_ready, input bit alt);
    int tries;
    for (int i = 0; i < n; i++) begin
      in_pixel = 24'($urandom);
      in_mode  = alt ? 2'(i % 3) : 2'($urandom_range(3));
      in_last  = alt ? (i == n - 1) : ($urandom_range(7) == 0);
      tries = 0;
      accepted = 0;
      while (!accepted && tries < 500) begin
        in_valid  = ($urandom_range(99) < p_valid);
        out_ready = ($urandom_range(99) < p_ready);
        cyc();
        tries++;
      end
      if (!accepted) chk("accept_timeout", accepted, 1'b1);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain(input int p_ready);
    int budget = 5000;
    while (q.size() > 0 && budget > 0) begin
      out_ready = ($urandom_range(99) < p_ready);
      cyc();
      budget--;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic single(input string tag, input logic [1:0] m, input logic [23:0] p,
                        input logic [23:0] exp);
    in_valid = 1; in_pixel = p; in_mode = m; in_last = 1; out_ready = 1;
    #1 chk({tag, "_rdy"}, in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 0; in_last = 0;
    for (int k = 1; k <= 3; k++) begin
      #1 chk($sformatf("%s_lat%0d", tag, k), out_valid, (k == 3));
      if (k < 3) begin @(posedge clk); @(negedge clk); end
    end
    chk({tag, "_val"}, {out_last, out_pixel}, {1'b1, exp});
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); @(negedge clk);
    clear = 0;
    q.delete(); stall_prev = 0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pixel", out_pixel, 24'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_pix_cnt", pix_cnt, 32'd0);
    @(negedge clk); rst = 0;
    @(negedge clk);

    // directed conversions with latency
    single("601_white", 2'd0, 24'hFFFFFF, {8'd255, 8'd128, 8'd128});
    single("601_black", 2'd0, 24'h000000, {8'd0, 8'd128, 8'd128});
    single("601_red",   2'd0, 24'hFF0000, {8'd76, 8'd85, 8'd255});
    single("709_green", 2'd1, 24'h00FF00, {8'd182, 8'd30, 8'd12});
    chk("cnt_after4", pix_cnt, 32'd4);

    // 16 back-to-back pixels, alternating modes, no backpressure
    do_clear();
    chk("cnt_cleared", pix_cnt, 32'd0);
    n_out = 0;
    stream(16, 100, 100, 1);
    drain(100);
    chk("b2b_count", n_out, 16);
    chk("b2b_consecutive", last_cyc - first_cyc, 15);
    chk("b2b_cnt", pix_cnt, 32'd16);

    // 1000 random pixels, random valid and 50% ready
    do_clear();
    n_out = 0;
    stream(1000, 80, 50, 0);
    drain(50);
    chk("rand_count", n_out, 1000);
    chk("rand_cnt", pix_cnt, 32'd1000);

    // clear with 3 pixels in flight and output stalled
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pixel = 24'($urandom); in_mode = 2'($urandom_range(3));
      cyc();
      chk($sformatf("fill_acc%0d", i), accepted, 1'b1);
    end
    #1 chk("full_not_ready", in_ready, 1'b0);
    clear = 1;
    #1 chk("clear_not_ready", in_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    clear = 0; in_valid = 0;
    q.delete(); stall_prev = 0;
    #1;
    chk("clear_out_valid", out_valid, 1'b0);
    chk("clear_cnt", pix_cnt, 32'd0);
    @(negedge clk);
    single("post_clear", 2'd0, 24'hFF0000, {8'd76, 8'd85, 8'd255});
    chk("post_clear_cnt", pix_cnt, 32'd1);

    // asynchronous reset mid-stream
    in_mode = 2'd2; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_pixel = 24'($urandom) | 24'h010101;
      out_ready = ($urandom_range(1) == 1);
      cyc();
    end
    #2 rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_pixel", out_pixel, 24'h0);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_pix_cnt", pix_cnt, 32'd0);
    chk("arst_in_ready", in_ready, 1'b1);
    in_valid = 0;
    q.delete(); stall_prev = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    n_out = 0;
    stream(50, 90, 70, 0);
    drain(70);
    chk("resume_count", n_out, 50);
    chk("resume_cnt", pix_cnt, 32'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
